// File: rtl/wb_load_store_unit.sv
// wb_load_store_unit
//   Wishbone (classic pipelined) master for the CPU memory stage. Each accepted
//   byte/half/word load or store becomes exactly one bus cycle; misaligned or
//   illegal-size requests complete without touching the bus.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req/i_we/i_addr/i_wdata    request strobe (sampled in IDLE), store flag,
//   i_size/i_unsigned            byte address, right-aligned store data,
//                                size (00 b, 01 h, 10 w, 11 illegal), zero-extend
//   o_busy, o_done               busy from accept through the done cycle; done pulse
//   o_rdata                      extended load data, held until next accept
//   o_misalign, o_err            completion status pulses (coincide with o_done)
//   o_wb_*                       Wishbone master outputs (cyc, stb, we, addr, data, sel)
//   i_wb_ack/stall/data          Wishbone slave responses
//
// Configuration
//   LSU_TIMEOUT_EN  when defined, a bus cycle that sees no ack for
//                   TIMEOUT_CYCLES cycles is aborted with o_err=1 and o_rdata=0.
//                   When undefined, o_err is never set and the unit waits forever.

module wb_load_store_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic              o_misalign,
  output logic              o_err,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [31:0]       o_wb_data,
  output logic [3:0]        o_wb_sel,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic [31:0]       i_wb_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STROBE = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_FIN    = 2'd3;

  // Size 11 is illegal; half needs addr[0]=0; word needs addr[1:0]=00.
  function automatic logic f_bad_req(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   f_bad_req = 1'b0;
      2'b01:   f_bad_req = lo[0];
      2'b10:   f_bad_req = (lo != 2'b00);
      default: f_bad_req = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] f_sel(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   f_sel = 4'b0001 << lo;
      2'b01:   f_sel = 4'b0011 << {lo[1], 1'b0};
      2'b10:   f_sel = 4'b1111;
      default: f_sel = 4'b0000;
    endcase
  endfunction

  // Replicate store data on every lane so the slave picks it up through sel.
  function automatic logic [31:0] f_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   f_lanes = {4{wdata[7:0]}};
      2'b01:   f_lanes = {2{wdata[15:0]}};
      default: f_lanes = wdata;
    endcase
  endfunction

  // Move the addressed lane down to bit 0 and extend it to 32 bits.
  function automatic logic [31:0] f_extract(input logic [31:0] data, input logic [1:0] lo,
                                            input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = data >> {lo, 3'b000};
    case (size)
      2'b00:   f_extract = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   f_extract = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
      default: f_extract = data;
    endcase
  endfunction

  logic [1:0]        r_state;
  logic [1:0]        r_size;
  logic [1:0]        r_addr_lo;
  logic              r_unsigned;
  logic              r_busy;
  logic              r_done;
  logic [31:0]       r_rdata;
  logic              r_misalign;
  logic              r_err;
  logic              r_wb_cyc;
  logic              r_wb_stb;
  logic              r_wb_we;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [31:0]       r_wb_data;
  logic [3:0]        r_wb_sel;
  logic              w_bad_req;
  logic              w_timeout;
  logic              w_in_bus;

  assign w_bad_req = f_bad_req(i_size, i_addr[1:0]);
  assign w_in_bus  = (r_state == S_STROBE) || (r_state == S_WAIT);

`ifdef LSU_TIMEOUT_EN
  localparam int         CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_tmo_cnt;

  // Counts bus-phase cycles since STROBE entry; restarts on every accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_tmo_cnt <= '0;
    end else if (w_in_bus) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_timeout = w_in_bus && (r_tmo_cnt == TMO_LAST);
`else
  // No abort path: the parameter only matters for the timeout build.
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES == 0) && w_in_bus;
`endif

  // Main FSM: request capture, Wishbone handshake and completion status.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_size     <= 2'b00;
      r_addr_lo  <= 2'b00;
      r_unsigned <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rdata    <= 32'h0000_0000;
      r_misalign <= 1'b0;
      r_err      <= 1'b0;
      r_wb_cyc   <= 1'b0;
      r_wb_stb   <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= 32'h0000_0000;
      r_wb_sel   <= 4'b0000;
    end else begin
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_busy     <= 1'b1;
            r_rdata    <= 32'h0000_0000;
            r_size     <= i_size;
            r_addr_lo  <= i_addr[1:0];
            r_unsigned <= i_unsigned;
            if (w_bad_req) begin
              r_state    <= S_FIN;
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
            end else begin
              r_state   <= S_STROBE;
              r_wb_cyc  <= 1'b1;
              r_wb_stb  <= 1'b1;
              r_wb_we   <= i_we;
              r_wb_addr <= {i_addr[ADDR_W-1:2], 2'b00};
              r_wb_data <= f_lanes(i_size, i_wdata);
              r_wb_sel  <= f_sel(i_size, i_addr[1:0]);
            end
          end
        end
        S_STROBE, S_WAIT: begin
          // An ack only counts in STROBE when the strobe is being accepted.
          if (i_wb_ack && ((r_state == S_WAIT) || !i_wb_stall)) begin
            if (!r_wb_we) begin
              r_rdata <= f_extract(i_wb_data, r_addr_lo, r_size, r_unsigned);
            end
            r_state   <= S_FIN;
            r_done    <= 1'b1;
            r_wb_cyc  <= 1'b0;
            r_wb_stb  <= 1'b0;
            r_wb_we   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= 32'h0000_0000;
            r_wb_sel  <= 4'b0000;
          end else if (w_timeout) begin
            r_rdata   <= 32'h0000_0000;
            r_state   <= S_FIN;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_wb_cyc  <= 1'b0;
            r_wb_stb  <= 1'b0;
            r_wb_we   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= 32'h0000_0000;
            r_wb_sel  <= 4'b0000;
          end else if ((r_state == S_STROBE) && !i_wb_stall) begin
            r_wb_stb <= 1'b0;
            r_state  <= S_WAIT;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rdata    = r_rdata;
  assign o_misalign = r_misalign;
  assign o_err      = r_err;
  assign o_wb_cyc   = r_wb_cyc;
  assign o_wb_stb   = r_wb_stb;
  assign o_wb_we    = r_wb_we;
  assign o_wb_addr  = r_wb_addr;
  assign o_wb_data  = r_wb_data;
  assign o_wb_sel   = r_wb_sel;

endmodule

// File: tb/tb_wb_load_store_unit.sv
// Directed bench for wb_load_store_unit (default build, timeout disabled).
module tb_wb_load_store_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_misalign;
  logic        o_err;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack;
  logic        i_wb_stall;
  logic [31:0] i_wb_data;

  int n_cmp = 0;
  int n_err = 0;

  wb_load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_size(i_size), .i_unsigned(i_unsigned),
    .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata), .o_misalign(o_misalign),
    .o_err(o_err), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Issues one request and acts as a zero-wait slave (ack in the cycle after
  // the strobe is accepted). Returns what was seen; lat is accept-to-done.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic uns, input logic [31:0] sdata,
                            output int lat, output logic [3:0] sel, output logic [31:0] wbd,
                            output logic [31:0] wba, output logic wbwe, output logic [31:0] rdata,
                            output logic mis, output logic saw_cyc, output logic busy_after,
                            output logic [31:0] rdata_after);
    i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata; i_size = size; i_unsigned = uns;
    tick;
    i_req = 1'b0;
    lat = 1; sel = 4'b0000; wbd = 32'h0; wba = 32'h0; wbwe = 1'b0; saw_cyc = 1'b0;
    while (!o_done && lat < 10) begin
      if (o_wb_cyc) saw_cyc = 1'b1;
      if (o_wb_stb) begin
        sel = o_wb_sel; wbd = o_wb_data; wba = o_wb_addr; wbwe = o_wb_we;
      end
      i_wb_ack  = o_wb_cyc && !o_wb_stb;
      i_wb_data = sdata;
      tick;
      i_wb_ack = 1'b0;
      lat++;
    end
    rdata = o_rdata;
    mis   = o_misalign;
    tick;
    busy_after  = o_busy;
    rdata_after = o_rdata;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    tick;
    tick;
    n_cmp++;
    if ({o_busy, o_done, o_misalign, o_err, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel} !== 11'd0) begin
      n_err++; $display("FAIL reset_ctrl got=%b want=0", {o_busy, o_done, o_misalign, o_err, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel});
    end
    n_cmp++;
    if ({o_rdata, o_wb_addr, o_wb_data} !== 96'd0) begin
      n_err++; $display("FAIL reset_data rdata=%h addr=%h data=%h want=0", o_rdata, o_wb_addr, o_wb_data);
    end
    i_rst = 1'b0;
    tick;
  endtask

  task automatic test_load_word;
    int lat; logic [3:0] sel; logic [31:0] wbd, wba, rd, rda; logic wbwe, mis, sc, ba;
    run_access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, lat, sel, wbd, wba, wbwe, rd, mis, sc, ba, rda);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL lw_latency got=%0d want=3", lat); end
    n_cmp++; if (sel !== 4'b1111) begin n_err++; $display("FAIL lw_sel got=%b want=1111", sel); end
    n_cmp++; if (wba !== 32'h10) begin n_err++; $display("FAIL lw_addr got=%h want=00000010", wba); end
    n_cmp++; if (wbwe !== 1'b0) begin n_err++; $display("FAIL lw_we got=%b want=0", wbwe); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_rdata got=%h want=deadbeef", rd); end
    n_cmp++; if (mis !== 1'b0) begin n_err++; $display("FAIL lw_misalign got=%b want=0", mis); end
    n_cmp++; if (ba !== 1'b0) begin n_err++; $display("FAIL lw_busy_after got=%b want=0", ba); end
    n_cmp++; if (rda !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_rdata_hold got=%h want=deadbeef", rda); end
  endtask

  task automatic test_load_subword;
    int lat; logic [3:0] sel; logic [31:0] wbd, wba, rd, rda; logic wbwe, mis, sc, ba;
    run_access(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 32'h80FF1234, lat, sel, wbd, wba, wbwe, rd, mis, sc, ba, rda);
    n_cmp++; if (sel !== 4'b1000) begin n_err++; $display("FAIL lb_sel got=%b want=1000", sel); end
    n_cmp++; if (rd !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_rdata got=%h want=ffffff80", rd); end
    n_cmp++; if (wba !== 32'h10) begin n_err++; $display("FAIL lb_addr got=%h want=00000010", wba); end
    run_access(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 32'h80FF1234, lat, sel, wbd, wba, wbwe, rd, mis, sc, ba, rda);
    n_cmp++; if (rd !== 32'h00000080) begin n_err++; $display("FAIL lbu_rdata got=%h want=00000080", rd); end
    run_access(1'b0, 32'h11, 32'h0, 2'b00, 1'b0, 32'h80FF1234, lat, sel, wbd, wba, wbwe, rd, mis, sc, ba, rda);
    n_cmp++; if (sel !== 4'b0010) begin n_err++; $display("FAIL lb1_sel got=%b want=0010", sel); end
    n_cmp++; if (rd !== 32'h00000012) begin n_err++; $display("FAIL lb1_rdata got=%h want=00000012", rd); end
    run_access(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 32'h80FF1234, lat, sel, wbd, wba, wbwe, rd, mis, sc, ba, rda);
    n_cmp++; if (sel !== 4'b1100) begin n_err++; $display("FAIL lh_sel got=%b want=1100", sel); end
    n_cmp++; if (rd !== 32'hFFFF80FF) begin n_err++; $display("FAIL lh_rdata got=%h want=ffff80ff", rd); end
    run_access(1'b0, 32'h10, 32'h0, 2'b01, 1'b1, 32'h80FF9234, lat, sel, wbd, wba, wbwe, rd, mis, sc, ba, rda);
    n_cmp++; if (sel !== 4'b0011) begin n_err++; $display("FAIL lhu_sel got=%b want=0011", sel); end
    n_cmp++; if (rd !== 32'h00009234) begin n_err++; $display("FAIL lhu_rdata got=%h want=00009234", rd); end
  endtask

  task automatic test_store;
    int lat; logic [3:0] sel; logic [31:0] wbd, wba, rd, rda; logic wbwe, mis, sc, ba;
    run_access(1'b1, 32'h22, 32'h0000ABCD, 2'b01, 1'b0, 32'h0, lat, sel, wbd, wba, wbwe, rd, mis, sc, ba, rda);
    n_cmp++; if (wbd !== 32'hABCDABCD) begin n_err++; $display("FAIL sh_data got=%h want=abcdabcd", wbd); end
    n_cmp++; if (sel !== 4'b1100) begin n_err++; $display("FAIL sh_sel got=%b want=1100", sel); end
    n_cmp++; if (wbwe !== 1'b1) begin n_err++; $display("FAIL sh_we got=%b want=1", wbwe); end
    n_cmp++; if (wba !== 32'h20) begin n_err++; $display("FAIL sh_addr got=%h want=00000020", wba); end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL sh_latency got=%0d want=3", lat); end
    n_cmp++; if (mis !== 1'b0) begin n_err++; $display("FAIL sh_misalign got=%b want=0", mis); end
    run_access(1'b1, 32'h21, 32'h123456A5, 2'b00, 1'b0, 32'h0, lat, sel, wbd, wba, wbwe, rd, mis, sc, ba, rda);
    n_cmp++; if (wbd !== 32'hA5A5A5A5) begin n_err++; $display("FAIL sb_data got=%h want=a5a5a5a5", wbd); end
    n_cmp++; if (sel !== 4'b0010) begin n_err++; $display("FAIL sb_sel got=%b want=0010", sel); end
    run_access(1'b1, 32'h24, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0, lat, sel, wbd, wba, wbwe, rd, mis, sc, ba, rda);
    n_cmp++; if (wbd !== 32'hCAFEF00D) begin n_err++; $display("FAIL sw_data got=%h want=cafef00d", wbd); end
    n_cmp++; if (sel !== 4'b1111) begin n_err++; $display("FAIL sw_sel got=%b want=1111", sel); end
  endtask

  task automatic test_misalign;
    int lat; logic [3:0] sel; logic [31:0] wbd, wba, rd, rda; logic wbwe, mis, sc, ba;
    run_access(1'b0, 32'h06, 32'h0, 2'b10, 1'b0, 32'h0, lat, sel, wbd, wba, wbwe, rd, mis, sc, ba, rda);
    n_cmp++; if (sc !== 1'b0) begin n_err++; $display("FAIL lw_mis_cyc got=%b want=0", sc); end
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL lw_mis_latency got=%0d want=1", lat); end
    n_cmp++; if (mis !== 1'b1) begin n_err++; $display("FAIL lw_mis_flag got=%b want=1", mis); end
    run_access(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, lat, sel, wbd, wba, wbwe, rd, mis, sc, ba, rda);
    n_cmp++; if ({sc, mis} !== 2'b01) begin n_err++; $display("FAIL size11_cyc_mis got=%b want=01", {sc, mis}); end
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL size11_latency got=%0d want=1", lat); end
    run_access(1'b1, 32'h13, 32'h0, 2'b01, 1'b0, 32'h0, lat, sel, wbd, wba, wbwe, rd, mis, sc, ba, rda);
    n_cmp++; if ({sc, mis} !== 2'b01) begin n_err++; $display("FAIL sh_mis_cyc_mis got=%b want=01", {sc, mis}); end
    n_cmp++; if (ba !== 1'b0) begin n_err++; $display("FAIL mis_busy_after got=%b want=0", ba); end
  endtask

  task automatic test_stall_and_busy_req;
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h40; i_size = 2'b10; i_unsigned = 1'b0;
    tick;
    i_addr = 32'h80; i_we = 1'b1;   // second request while busy: must be ignored
    i_wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel} !== 7'b1101111 || o_wb_addr !== 32'h40) begin
        n_err++; $display("FAIL stall_hold_%0d cyc_stb_we_sel=%b addr=%h want=1101111 addr=00000040", k, {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel}, o_wb_addr);
      end
      tick;
    end
    i_wb_stall = 1'b0;
    i_req = 1'b0;
    n_cmp++; if (o_wb_stb !== 1'b1) begin n_err++; $display("FAIL stall_stb_after got=%b want=1", o_wb_stb); end
    tick;
    n_cmp++; if ({o_wb_cyc, o_wb_stb} !== 2'b10) begin n_err++; $display("FAIL stall_wait got=%b want=10", {o_wb_cyc, o_wb_stb}); end
    i_wb_ack = 1'b1; i_wb_data = 32'h11223344;
    tick;
    i_wb_ack = 1'b0;
    n_cmp++; if ({o_done, o_wb_cyc} !== 2'b10 || o_rdata !== 32'h11223344) begin
      n_err++; $display("FAIL stall_done done_cyc=%b rdata=%h want=10 11223344", {o_done, o_wb_cyc}, o_rdata);
    end
    tick;
    tick;
    n_cmp++; if ({o_busy, o_wb_cyc, o_done} !== 3'b000) begin n_err++; $display("FAIL busy_req_ignored got=%b want=000", {o_busy, o_wb_cyc, o_done}); end
  endtask

  task automatic test_ack_edge_cases;
    // Ack while idle must not produce anything.
    i_wb_ack = 1'b1; i_wb_data = 32'hFFFF_FFFF;
    tick;
    tick;
    n_cmp++; if ({o_done, o_busy} !== 2'b00) begin n_err++; $display("FAIL idle_ack got=%b want=00", {o_done, o_busy}); end
    // Ack in the same cycle the strobe is accepted: straight to FIN.
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h30; i_size = 2'b10; i_unsigned = 1'b0;
    i_wb_ack = 1'b0;
    tick;
    i_req = 1'b0;
    i_wb_ack = 1'b1; i_wb_data = 32'hA5A50F0F;
    tick;
    i_wb_ack = 1'b0;
    n_cmp++; if ({o_done, o_wb_cyc, o_wb_stb} !== 3'b100 || o_rdata !== 32'hA5A50F0F) begin
      n_err++; $display("FAIL strobe_ack done_cyc_stb=%b rdata=%h want=100 a5a50f0f", {o_done, o_wb_cyc, o_wb_stb}, o_rdata);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h50; i_size = 2'b10; i_unsigned = 1'b0;
    tick;
    i_req = 1'b0;
    tick;
    n_cmp++; if ({o_wb_cyc, o_wb_stb} !== 2'b10) begin n_err++; $display("FAIL rst_mid_wait got=%b want=10", {o_wb_cyc, o_wb_stb}); end
    i_rst = 1'b1;
    tick;
    n_cmp++; if ({o_wb_cyc, o_wb_stb, o_busy, o_done} !== 4'b0000) begin n_err++; $display("FAIL rst_mid_drop got=%b want=0000", {o_wb_cyc, o_wb_stb, o_busy, o_done}); end
    i_rst = 1'b0;
    i_wb_ack = 1'b1;
    tick;
    i_wb_ack = 1'b0;
    tick;
    n_cmp++; if ({o_wb_cyc, o_busy, o_done} !== 3'b000) begin n_err++; $display("FAIL rst_mid_after got=%b want=000", {o_wb_cyc, o_busy, o_done}); end
  endtask

  initial begin
    i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = 32'h0; i_wdata = 32'h0;
    i_size = 2'b00; i_unsigned = 1'b0; i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = 32'h0;
    test_reset;
    test_load_word;
    test_load_subword;
    test_store;
    test_misalign;
    test_stall_and_busy_req;
    test_ack_edge_cases;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
